// File: rtl/cpu_mmu_pkg.sv
// cpu_mmu_pkg
// Shared types and constants for the paged-mode LA->PPN translator
// (cpu_ppn_xlat) and its page index table storage (cpu_pit_ram).
//   - xlatState_e : translator FSM states
//   - ACC_*       : ACCESS_1_0 codes
//   - FC_*        : FAULT_CODE_1_0 values
//   - ENTRY_*     : PIT entry field bit positions
//   - PIT_DEPTH / ENTRY_W / STORE_W : table geometry
// Optional feature macro: CPU_PPN_XLAT_PARITY_EN adds one stored even-parity
// bit per entry (STORE_W = 18) and the evenParity helper.
package cpu_mmu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } xlatState_e;

  localparam logic [1:0] ACC_READ  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;
  localparam logic [1:0] ACC_FETCH = 2'b10;
  localparam logic [1:0] ACC_RSVD  = 2'b11;

  localparam logic [1:0] FC_NONE        = 2'b00;
  localparam logic [1:0] FC_NOT_PRESENT = 2'b01;
  localparam logic [1:0] FC_PERM        = 2'b10;
  localparam logic [1:0] FC_PARITY      = 2'b11;

  localparam int ENTRY_WPM     = 16;
  localparam int ENTRY_RPM     = 15;
  localparam int ENTRY_FPM     = 14;
  localparam int ENTRY_PPN_MSB = 13;
  localparam int PPN_W         = 14;

  localparam int PIT_DEPTH  = 256;
  localparam int PIT_ADDR_W = 8;
  localparam int ENTRY_W    = 17;

`ifdef CPU_PPN_XLAT_PARITY_EN
  localparam int STORE_W = ENTRY_W + 1;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic evenParity(input logic [ENTRY_W-1:0] data);
    return ^data;
  endfunction
`else
  localparam int STORE_W = ENTRY_W;
`endif

endpackage

// File: rtl/cpu_ppn_xlat_if.sv
// cpu_ppn_xlat_if
// Bus bundle between the address sequencer / CPU (master) and the
// translator (slave).
//   Translation: LAPA_n, REQ, ACCESS_1_0, PIT_1_0, LA_23_10 -> slave;
//                ACK, PPN_23_10, FAULT, FAULT_CODE_1_0       -> master.
//   PIT port:    PT_WE, PT_ADDR_7_0, PT_WDATA_16_0 (and PT_PARINV when
//                CPU_PPN_XLAT_PARITY_EN is defined) -> slave;
//                PT_RDATA_16_0 -> master.
interface cpu_ppn_xlat_if;
  import cpu_mmu_pkg::*;

  logic                  LAPA_n;
  logic                  REQ;
  logic [1:0]            ACCESS_1_0;
  logic [1:0]            PIT_1_0;
  logic [PPN_W-1:0]      LA_23_10;
  logic                  ACK;
  logic [PPN_W-1:0]      PPN_23_10;
  logic                  FAULT;
  logic [1:0]            FAULT_CODE_1_0;
  logic                  PT_WE;
  logic [PIT_ADDR_W-1:0] PT_ADDR_7_0;
  logic [ENTRY_W-1:0]    PT_WDATA_16_0;
  logic [ENTRY_W-1:0]    PT_RDATA_16_0;
`ifdef CPU_PPN_XLAT_PARITY_EN
  logic                  PT_PARINV;
`endif

  modport master (
    output LAPA_n, REQ, ACCESS_1_0, PIT_1_0, LA_23_10,
    output PT_WE, PT_ADDR_7_0, PT_WDATA_16_0,
`ifdef CPU_PPN_XLAT_PARITY_EN
    output PT_PARINV,
`endif
    input  ACK, PPN_23_10, FAULT, FAULT_CODE_1_0, PT_RDATA_16_0
  );

  modport slave (
    input  LAPA_n, REQ, ACCESS_1_0, PIT_1_0, LA_23_10,
    input  PT_WE, PT_ADDR_7_0, PT_WDATA_16_0,
`ifdef CPU_PPN_XLAT_PARITY_EN
    input  PT_PARINV,
`endif
    output ACK, PPN_23_10, FAULT, FAULT_CODE_1_0, PT_RDATA_16_0
  );

endinterface

// File: rtl/cpu_pit_ram.sv
// cpu_pit_ram
// Page index table storage: PIT_DEPTH x STORE_W bits (17, or 18 with
// CPU_PPN_XLAT_PARITY_EN). All entries clear on reset (= not present).
//   CLK, RESET_n      : clock, asynchronous active-low reset
//   wrEn/wrAddr/wrData: synchronous write port
//   lkEn/lkAddr       : lookup read, captured into lkDataR only when lkEn
//   rdAddr            : CPU read-back, captured into rdDataR every cycle
// Both read ports sample the array before a same-edge write lands, so a
// read and a write of the same index on one edge return the old entry.
module cpu_pit_ram
  import cpu_mmu_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  wrEn,
  input  logic [PIT_ADDR_W-1:0] wrAddr,
  input  logic [STORE_W-1:0]    wrData,
  input  logic                  lkEn,
  input  logic [PIT_ADDR_W-1:0] lkAddr,
  output logic [STORE_W-1:0]    lkDataR,
  input  logic [PIT_ADDR_W-1:0] rdAddr,
  output logic [ENTRY_W-1:0]    rdDataR
);

  logic [STORE_W-1:0] memR [PIT_DEPTH];

  // Entry array: cleared on reset, otherwise written through the single port.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < PIT_DEPTH; i++) begin
        memR[i] <= '0;
      end
    end else if (wrEn) begin
      memR[wrAddr] <= wrData;
    end
  end

  // Lookup register: loads only on the edge that starts a translation.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      lkDataR <= '0;
    end else if (lkEn) begin
      lkDataR <= memR[lkAddr];
    end
  end

  // CPU read-back register: follows rdAddr every cycle, parity bit excluded.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rdDataR <= '0;
    end else begin
      rdDataR <= memR[rdAddr][ENTRY_W-1:0];
    end
  end

endmodule

// File: rtl/cpu_ppn_xlat.sv
// cpu_ppn_xlat
// Paged-mode LA->PPN translator. With LAPA_n low the request bypasses the
// table and PPN = LA_23_10; with LAPA_n high the entry {PIT_1_0, LA[5:0]}
// is read from the page index table and checked for presence/permission.
// Each request is answered with a one-cycle ACK; PPN/FAULT/FAULT_CODE hold
// until the next response.
//   CLK, RESET_n : clock, asynchronous active-low reset
//   bus          : cpu_ppn_xlat_if.slave (translation handshake + PIT port)
// Optional feature macro: CPU_PPN_XLAT_PARITY_EN (stored entry parity,
// PT_PARINV test input, fault code 11 on mismatch).
module cpu_ppn_xlat
  import cpu_mmu_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET_n,
  cpu_ppn_xlat_if.slave bus
);

  xlatState_e         stateR;
  xlatState_e         stateNextS;
  logic               lookupStartS;
  logic [STORE_W-1:0] wrDataS;
  logic [STORE_W-1:0] lkDataS;
  logic [1:0]         accessR;
  logic               permOkS;
  logic               notPresentS;
  logic               parityErrS;
  logic               ackR;
  logic [PPN_W-1:0]   ppnR;
  logic               faultR;
  logic [1:0]         faultCodeR;
  logic [PPN_W-1:0]   ppnNextS;
  logic               faultNextS;
  logic [1:0]         faultCodeNextS;

`ifdef CPU_PPN_XLAT_PARITY_EN
  // PT_PARINV flips the stored parity so the fault path can be exercised.
  assign wrDataS    = {evenParity(bus.PT_WDATA_16_0) ^ bus.PT_PARINV, bus.PT_WDATA_16_0};
  assign parityErrS = evenParity(lkDataS[ENTRY_W-1:0]) != lkDataS[ENTRY_W];
`else
  assign wrDataS    = bus.PT_WDATA_16_0;
  assign parityErrS = 1'b0;
`endif

  cpu_pit_ram uPitRam (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .wrEn    (bus.PT_WE),
    .wrAddr  (bus.PT_ADDR_7_0),
    .wrData  (wrDataS),
    .lkEn    (lookupStartS),
    .lkAddr  ({bus.PIT_1_0, bus.LA_23_10[5:0]}),
    .lkDataR (lkDataS),
    .rdAddr  (bus.PT_ADDR_7_0),
    .rdDataR (bus.PT_RDATA_16_0)
  );

  // Next-state logic; request inputs are only looked at in IDLE.
  always_comb begin
    stateNextS   = stateR;
    lookupStartS = 1'b0;
    case (stateR)
      IDLE: begin
        if (bus.REQ) begin
          if (bus.LAPA_n) begin
            stateNextS   = LOOKUP;
            lookupStartS = 1'b1;
          end else begin
            stateNextS = RESP;
          end
        end else begin
          stateNextS = IDLE;
        end
      end
      LOOKUP:  stateNextS = RESP;
      RESP:    stateNextS = IDLE;
      default: stateNextS = IDLE;
    endcase
  end

  // Permission bit selected by the access type latched at request time.
  always_comb begin
    permOkS = 1'b0;
    case (accessR)
      ACC_WRITE: permOkS = lkDataS[ENTRY_WPM];
      ACC_FETCH: permOkS = lkDataS[ENTRY_FPM];
      ACC_READ,
      ACC_RSVD:  permOkS = lkDataS[ENTRY_RPM];
      default:   permOkS = lkDataS[ENTRY_RPM];
    endcase
  end

  assign notPresentS = ~|{lkDataS[ENTRY_WPM], lkDataS[ENTRY_RPM], lkDataS[ENTRY_FPM]};

  // Response values: loaded on the edge entering RESP, held otherwise.
  always_comb begin
    ppnNextS       = ppnR;
    faultNextS     = faultR;
    faultCodeNextS = faultCodeR;
    if (stateR == IDLE && bus.REQ && !bus.LAPA_n) begin
      ppnNextS       = bus.LA_23_10;
      faultNextS     = 1'b0;
      faultCodeNextS = FC_NONE;
    end else if (stateR == LOOKUP) begin
      ppnNextS = lkDataS[ENTRY_PPN_MSB:0];
      // Priority: parity > not present > permission.
      if (parityErrS) begin
        faultNextS     = 1'b1;
        faultCodeNextS = FC_PARITY;
      end else if (notPresentS) begin
        faultNextS     = 1'b1;
        faultCodeNextS = FC_NOT_PRESENT;
      end else if (!permOkS) begin
        faultNextS     = 1'b1;
        faultCodeNextS = FC_PERM;
      end else begin
        faultNextS     = 1'b0;
        faultCodeNextS = FC_NONE;
      end
    end else begin
      ppnNextS       = ppnR;
      faultNextS     = faultR;
      faultCodeNextS = faultCodeR;
    end
  end

  // State, latched access type and registered response outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      stateR     <= IDLE;
      accessR    <= ACC_READ;
      ackR       <= 1'b0;
      ppnR       <= '0;
      faultR     <= 1'b0;
      faultCodeR <= FC_NONE;
    end else begin
      stateR     <= stateNextS;
      ackR       <= (stateNextS == RESP);
      ppnR       <= ppnNextS;
      faultR     <= faultNextS;
      faultCodeR <= faultCodeNextS;
      if (lookupStartS) begin
        accessR <= bus.ACCESS_1_0;
      end
    end
  end

  assign bus.ACK            = ackR;
  assign bus.PPN_23_10      = ppnR;
  assign bus.FAULT          = faultR;
  assign bus.FAULT_CODE_1_0 = faultCodeR;

endmodule

// File: tb/tb_cpu_ppn_xlat.sv
// tb_cpu_ppn_xlat
// Self-checking bench for cpu_ppn_xlat: reset state, a table of directed
// translate/bypass vectors, hand-written multi-cycle sequences (same-edge
// write/read, REQ held high, reset during LOOKUP, optional parity) and
// randomized requests checked against a table-level reference model.
module tb_cpu_ppn_xlat;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  cpu_ppn_xlat_if bus();

  cpu_ppn_xlat dut (
    .CLK     (clk),
    .RESET_n (rstN),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference view of the page index table.
  logic [16:0] pitModel [256];
  bit          parBad   [256];

  typedef struct {
    logic        wr;
    logic [7:0]  wIdx;
    logic [16:0] wData;
    logic        lapa;
    logic [1:0]  pit;
    logic [13:0] la;
    logic [1:0]  acc;
    logic [13:0] ePpn;
    logic        eFault;
    logic [1:0]  eCode;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference translation computed from the table contents and access rules.
  function automatic void refXlat(input logic lapa, input logic [1:0] pit, input logic [13:0] la,
                                  input logic [1:0] acc, output logic [13:0] ppn,
                                  output logic fault, output logic [1:0] code);
    int          idx;
    logic [16:0] e;
    logic        allowed;
    ppn   = la;
    fault = 1'b0;
    code  = 2'b00;
    if (lapa) begin
      idx = int'(pit) * 64 + int'(la) % 64;
      e   = pitModel[idx];
      ppn = e[13:0];
      if (acc == 2'b01)      allowed = e[16];
      else if (acc == 2'b10) allowed = e[14];
      else                   allowed = e[15];
      if (parBad[idx]) begin
        fault = 1'b1; code = 2'b11;
      end else if (e[16:14] == 3'b000) begin
        fault = 1'b1; code = 2'b01;
      end else if (!allowed) begin
        fault = 1'b1; code = 2'b10;
      end
    end
  endfunction

  task automatic ptWrite(input logic [7:0] idx, input logic [16:0] data, input logic parinv);
    logic [16:0] old;
    old = pitModel[idx];
    bus.PT_WE         = 1'b1;
    bus.PT_ADDR_7_0   = idx;
    bus.PT_WDATA_16_0 = data;
`ifdef CPU_PPN_XLAT_PARITY_EN
    bus.PT_PARINV = parinv;
`endif
    step();
    bus.PT_WE = 1'b0;
`ifdef CPU_PPN_XLAT_PARITY_EN
    bus.PT_PARINV = 1'b0;
`endif
    chk("pt_wr_rd_old", 32'(bus.PT_RDATA_16_0), 32'(old));
    pitModel[idx] = data;
    parBad[idx]   = parinv;
  endtask

  task automatic ptRead(input logic [7:0] idx);
    bus.PT_ADDR_7_0 = idx;
    step();
    chk("pt_rd", 32'(bus.PT_RDATA_16_0), 32'(pitModel[idx]));
  endtask

  // Issue one request, scramble inputs after the sampling edge, wait (bounded) for ACK.
  task automatic runReq(input string name, input logic lapa, input logic [1:0] pit,
                        input logic [13:0] la, input logic [1:0] acc, input logic [13:0] ePpn,
                        input logic eFault, input logic [1:0] eCode);
    int lat;
    int expLat;
    expLat         = lapa ? 2 : 1;
    bus.LAPA_n     = lapa;
    bus.PIT_1_0    = pit;
    bus.LA_23_10   = la;
    bus.ACCESS_1_0 = acc;
    bus.REQ        = 1'b1;
    step();
    bus.REQ        = 1'b0;
    bus.LAPA_n     = ~lapa;
    bus.PIT_1_0    = ~pit;
    bus.LA_23_10   = ~la;
    bus.ACCESS_1_0 = ~acc;
    lat = 1;
    while (bus.ACK !== 1'b1 && lat < 6) begin
      step();
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'(expLat));
    chk({name, "_fault"}, 32'(bus.FAULT), 32'(eFault));
    chk({name, "_code"}, 32'(bus.FAULT_CODE_1_0), 32'(eCode));
    if (!eFault) chk({name, "_ppn"}, 32'(bus.PPN_23_10), 32'(ePpn));
    step();
    chk({name, "_ackdrop"}, 32'(bus.ACK), 32'(1'b0));
    chk({name, "_hold"}, 32'(bus.FAULT_CODE_1_0), 32'(eCode));
  endtask

  task automatic doReq(input string name, input logic lapa, input logic [1:0] pit,
                       input logic [13:0] la, input logic [1:0] acc);
    logic [13:0] p;
    logic        f;
    logic [1:0]  c;
    refXlat(lapa, pit, la, acc, p, f, c);
    runReq(name, lapa, pit, la, acc, p, f, c);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) begin
      pitModel[i] = 17'h0;
      parBad[i]   = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  idx;
    logic        lapa;
    logic [1:0]  pit;
    logic [13:0] la;
    logic [1:0]  acc;

    //                wr    idx    data       lapa  pit    la        acc    ppn       flt   code
    vecs[0]  = '{1'b1, 8'h95, 17'h1C123, 1'b1, 2'd2, 14'h0015, 2'b10, 14'h0123, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 8'h00, 17'h00000, 1'b0, 2'd0, 14'h2A5F, 2'b00, 14'h2A5F, 1'b0, 2'b00};
    vecs[2]  = '{1'b1, 8'h7F, 17'h04ABC, 1'b1, 2'd1, 14'h3FFF, 2'b01, 14'h0000, 1'b1, 2'b10};
    vecs[3]  = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd1, 14'h00BF, 2'b10, 14'h0ABC, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd1, 14'h003F, 2'b00, 14'h0000, 1'b1, 2'b10};
    vecs[5]  = '{1'b1, 8'h01, 17'h0BEEF, 1'b1, 2'd0, 14'h3C01, 2'b00, 14'h3EEF, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd0, 14'h0001, 2'b11, 14'h3EEF, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd0, 14'h0041, 2'b10, 14'h0000, 1'b1, 2'b10};
    vecs[8]  = '{1'b1, 8'hE0, 17'h10000, 1'b1, 2'd3, 14'h0020, 2'b01, 14'h0000, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd3, 14'h0020, 2'b00, 14'h0000, 1'b1, 2'b10};
    vecs[10] = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd3, 14'h0021, 2'b00, 14'h0000, 1'b1, 2'b01};
    vecs[11] = '{1'b1, 8'hE1, 17'h00FFF, 1'b1, 2'd3, 14'h0021, 2'b10, 14'h0000, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 8'h00, 17'h00000, 1'b0, 2'd3, 14'h1555, 2'b01, 14'h1555, 1'b0, 2'b00};
    vecs[13] = '{1'b0, 8'h00, 17'h00000, 1'b1, 2'd2, 14'h1F15, 2'b01, 14'h0123, 1'b0, 2'b00};

    rstN              = 1'b0;
    bus.REQ           = 1'b0;
    bus.LAPA_n        = 1'b0;
    bus.ACCESS_1_0    = 2'b00;
    bus.PIT_1_0       = 2'b00;
    bus.LA_23_10      = 14'h0;
    bus.PT_WE         = 1'b0;
    bus.PT_ADDR_7_0   = 8'h00;
    bus.PT_WDATA_16_0 = 17'h0;
`ifdef CPU_PPN_XLAT_PARITY_EN
    bus.PT_PARINV = 1'b0;
`endif
    clearModel();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ACK), 32'(1'b0));
    chk("rst_ppn", 32'(bus.PPN_23_10), 32'(14'h0));
    chk("rst_fault", 32'(bus.FAULT), 32'(1'b0));
    chk("rst_code", 32'(bus.FAULT_CODE_1_0), 32'(2'b00));
    chk("rst_rdata", 32'(bus.PT_RDATA_16_0), 32'(17'h0));
    rstN = 1'b1;

    for (int a = 0; a < 256; a++) ptRead(8'(a));
    runReq("empty_xlat", 1'b1, 2'd3, 14'h1234, 2'b00, 14'h0, 1'b1, 2'b01);

    // Directed table.
    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].wr) ptWrite(vecs[v].wIdx, vecs[v].wData, 1'b0);
      runReq($sformatf("vec%0d", v), vecs[v].lapa, vecs[v].pit, vecs[v].la, vecs[v].acc,
             vecs[v].ePpn, vecs[v].eFault, vecs[v].eCode);
    end

    // Write and read-back of one index on the same edge.
    bus.PT_ADDR_7_0 = 8'h33;
    ptWrite(8'h33, 17'h15A5A, 1'b0);
    ptRead(8'h33);

    // Table write on the lookup-start edge: lookup sees the old entry.
    ptWrite(8'h10, 17'h0C111, 1'b0);
    bus.LAPA_n = 1'b1; bus.PIT_1_0 = 2'd0; bus.LA_23_10 = 14'h0010; bus.ACCESS_1_0 = 2'b00;
    bus.REQ = 1'b1;
    bus.PT_WE = 1'b1; bus.PT_ADDR_7_0 = 8'h10; bus.PT_WDATA_16_0 = 17'h00000;
    step();
    bus.PT_WE = 1'b0; bus.REQ = 1'b0;
    pitModel[8'h10] = 17'h00000;
    step();
    chk("wr_lk_ack", 32'(bus.ACK), 32'(1'b1));
    chk("wr_lk_fault", 32'(bus.FAULT), 32'(1'b0));
    chk("wr_lk_ppn", 32'(bus.PPN_23_10), 32'(14'h0111));
    step();
    runReq("wr_lk_after", 1'b1, 2'd0, 14'h0010, 2'b00, 14'h0, 1'b1, 2'b01);

    // REQ held high through back-to-back translations; LA moved during LOOKUP.
    ptWrite(8'h45, 17'h0C0AA, 1'b0);
    ptWrite(8'h46, 17'h0C0BB, 1'b0);
    bus.LAPA_n = 1'b1; bus.PIT_1_0 = 2'd1; bus.LA_23_10 = 14'h0005; bus.ACCESS_1_0 = 2'b00;
    bus.REQ = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus.LA_23_10 = 14'h0006;
      if (c == 5) bus.REQ = 1'b0;
      chk($sformatf("held_ack_c%0d", c), 32'(bus.ACK), 32'((c == 2 || c == 5) ? 1 : 0));
      if (c == 2) chk("held_ppn_first", 32'(bus.PPN_23_10), 32'(14'h00AA));
      if (c == 5) chk("held_ppn_second", 32'(bus.PPN_23_10), 32'(14'h00BB));
    end

    // Back-to-back bypass: ACK every second cycle.
    bus.LAPA_n = 1'b0; bus.LA_23_10 = 14'h3ABC; bus.REQ = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) bus.REQ = 1'b0;
      chk($sformatf("byp_ack_c%0d", c), 32'(bus.ACK), 32'((c % 2 == 1) ? 1 : 0));
    end
    chk("byp_ppn", 32'(bus.PPN_23_10), 32'(14'h3ABC));

`ifdef CPU_PPN_XLAT_PARITY_EN
    ptWrite(8'h99, 17'h00000, 1'b1);
    runReq("par_np", 1'b1, 2'd2, 14'h0019, 2'b00, 14'h0, 1'b1, 2'b11);
    ptWrite(8'h99, 17'h1C777, 1'b1);
    runReq("par_valid", 1'b1, 2'd2, 14'h0019, 2'b00, 14'h0, 1'b1, 2'b11);
    ptWrite(8'h99, 17'h1C777, 1'b0);
    runReq("par_clean", 1'b1, 2'd2, 14'h0019, 2'b00, 14'h0777, 1'b0, 2'b00);
`endif

    // Reset pulsed during LOOKUP aborts the request and clears the table.
    bus.PT_ADDR_7_0 = 8'h95;
    bus.LAPA_n = 1'b1; bus.PIT_1_0 = 2'd2; bus.LA_23_10 = 14'h0015; bus.ACCESS_1_0 = 2'b10;
    bus.REQ = 1'b1;
    step();
    bus.REQ = 1'b0;
    rstN = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ACK), 32'(1'b0));
    chk("midrst_ppn", 32'(bus.PPN_23_10), 32'(14'h0));
    chk("midrst_fault", 32'(bus.FAULT), 32'(1'b0));
    chk("midrst_code", 32'(bus.FAULT_CODE_1_0), 32'(2'b00));
    clearModel();
    step();
    step();
    chk("midrst_ack_late", 32'(bus.ACK), 32'(1'b0));
    chk("midrst_rdata", 32'(bus.PT_RDATA_16_0), 32'(17'h0));
    rstN = 1'b1;
    step();
    chk("postrst_noack", 32'(bus.ACK), 32'(1'b0));
    doReq("postrst_xlat", 1'b1, 2'd2, 14'h0015, 2'b10);
    doReq("postrst_byp", 1'b0, 2'd0, 14'h2A5F, 2'b00);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      idx = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) ptWrite(idx, 17'($urandom()), 1'b0);
      lapa = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        pit = idx[7:6];
        la  = {8'($urandom()), idx[5:0]};
      end else begin
        pit = 2'($urandom());
        la  = 14'($urandom());
      end
      acc = 2'($urandom());
      doReq("rand", lapa, pit, la, acc);
      if (i % 10 == 0) ptRead(idx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ppn_xlat.md
# cpu_ppn_xlat

Paged-mode counterpart of the CPU's LA→PPN bypass buffer: when paging is on (LAPA_n high), it translates logical page bits to a 14-bit physical page number. The translation uses a 4×64-entry page index table (PIT). When LAPA_n is low, it passes LA_23_10 straight through. It sits between the address sequencer and the memory address bus driver and answers each translation request with a REQ/ACK handshake and fault reporting. The CPU loads the PIT through a separate write/read port.

## Interface
Parameters: none. All widths are fixed by the ND-120 address map.

- CLK  in  1  system clock; all state updates on rising edge
- RESET_n  in  1  asynchronous, active-low reset
- LAPA_n  in  1  0 = bypass (no translation), 1 = translate via PIT
- REQ  in  1  translation request; sampled only in IDLE
- ACCESS_1_0  in  2  00 read, 01 write, 10 fetch, 11 reserved (treated as read)
- PIT_1_0  in  2  active PIT number
- LA_23_10  in  14  logical address bits 23:10; PIT index uses LA_23_10[5:0]
- ACK  out  1  one-cycle pulse; PPN/FAULT valid from this cycle on
- PPN_23_10  out  14  physical page number
- FAULT  out  1  request faulted; PPN_23_10 is don't-care when set
- FAULT_CODE_1_0  out  2  00 none, 01 page not present, 10 permission, 11 parity
- PT_WE  in  1  PIT write strobe
- PT_ADDR_7_0  in  8  entry index {PIT, page}
- PT_WDATA_16_0  in  17  entry: [16] WPM, [15] RPM, [14] FPM, [13:0] PPN
- PT_RDATA_16_0  out  17  registered read of PT_ADDR_7_0

## Operation
- States: IDLE, LOOKUP, RESP.
- In IDLE with REQ=1 and LAPA_n=0, go to RESP.
  - The response registers load PPN = LA_23_10 and FAULT = 0.
- In IDLE with REQ=1 and LAPA_n=1, go to LOOKUP.
  - The entry at {PIT_1_0, LA_23_10[5:0]} is read into a register on this edge.
- LOOKUP → RESP.
  - The response registers load PPN = entry[13:0].
  - Fault priority, highest first: parity (11) > not present, i.e. WPM=RPM=FPM=0 (01) > permission bit for ACCESS missing (10).
- RESP → IDLE. ACK=1 for exactly this cycle.
- PPN_23_10, FAULT and FAULT_CODE_1_0 hold their values until the next RESP.
- REQ, LA, PIT, ACCESS and LAPA_n are sampled only on the IDLE edge. Changes afterwards are ignored.
- REQ still high in IDLE after RESP starts a new request. The minimum gap between ACKs is 2 cycles for bypass and 3 for translate.
- PT_WE writes PT_WDATA_16_0 at PT_ADDR_7_0 in any state.
  - A write to the index being looked up, on the same edge as the IDLE→LOOKUP read, returns the old data.
- PT_RDATA_16_0 is the entry at PT_ADDR_7_0 registered each cycle.
  - A write and a read-back of the same index on the same edge returns the old data.

## Timing
- Bypass: REQ sampled at edge N, ACK high during cycle N+1.
- Translate: REQ sampled at edge N, ACK high during cycle N+2.
- PT write latency: 1 edge. PT_RDATA latency: 1 edge.
- Reset values:
  - State: IDLE.
  - ACK, FAULT: 0. FAULT_CODE_1_0: 00.
  - PPN_23_10: 0. PT_RDATA_16_0: 0.
  - All PIT entries: 0 (not present).
- Reset asserted mid-operation aborts the request with no ACK. The first request after release behaves as from IDLE.

## Configuration
- CPU_PPN_XLAT_PARITY_EN defined:
  - Each entry stores an extra even-parity bit over bits 16:0, computed on write.
  - A mismatch on lookup gives fault 11.
  - A test input PT_PARINV inverts the stored parity bit on write.
- Not defined:
  - No parity storage and no PT_PARINV port.
  - Fault code 11 is never produced.

## Structure
- Package cpu_mmu_pkg holds:
  - state enum
  - ACCESS codes
  - FAULT_CODE values
  - entry field bit positions (WPM/RPM/FPM/PPN)
  - PIT depth (256) and entry width
- Sub-module cpu_pit_ram: 256×17 (18 with parity) storage.
  - Async-reset clear.
  - One synchronous write port.
  - Two registered read ports: lookup and PT_RDATA.
- The top level holds the FSM, fault logic and response registers.

## Test plan
- Reset, then read PT_ADDR=0x00..0xFF → all 0; a translate request to any index → ACK at N+2, FAULT=1, code 01.
- LAPA_n=0, REQ with LA_23_10=0x2A5F → ACK at N+1, PPN=0x2A5F, FAULT=0.
- Write 0x1C123 at index {PIT=2, page=0x15}:
  - fetch (ACCESS=10) with PIT=2, LA_23_10[5:0]=0x15 → PPN=0x0123, FAULT=0.
  - write (ACCESS=01) → FAULT=1, code 10.
- Translate request with REQ held high for 6 cycles → ACKs at cycles 2 and 5 only; LA changes during LOOKUP do not affect PPN.
- RESET_n pulsed low during LOOKUP → no ACK, outputs 0, the next request completes normally.
- With CPU_PPN_XLAT_PARITY_EN: write an entry with PT_PARINV=1, then look it up → FAULT=1, code 11, even if the entry is otherwise not present.
